// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: freezes or bubbles the pipeline registers for
// data-memory wait states, load-use hazards and taken branches; counts stall cycles.
module hazard_ctrl #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  id_rs1,
   input  logic [2:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [2:0]  ex_wreg,
   input  logic        ex_rwrite,
   input  logic        ex_mread,
   input  logic        ex_branch_taken,
   input  logic        mem_mread,
   input  logic        mem_mwrite,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        memwb_flush,
   output logic        pc_take_branch,
   output logic [15:0] stall_cycles
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   localparam logic [3:0] WaitInit = 4'(MEM_WAIT - 1);

   logic [0:0]  state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [15:0] stall_cycles_q;
   logic        mem_stall;
   logic        lu_stall;
   logic        count_en;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_stall = 1'b0;
      if (MEM_WAIT != 0) begin
         case (state_q)
            StIdle: begin
               if (mem_mread | mem_mwrite) begin
                  mem_stall = 1'b1;
                  state_d   = StWait;
                  wcnt_d    = WaitInit;
               end
            end
            default: begin
               if (wcnt_q != 4'd0) begin
                  mem_stall = 1'b1;
                  wcnt_d    = wcnt_q - 4'd1;
               end else begin
                  state_d = StIdle;
               end
            end
         endcase
      end
   end

   assign lu_stall = ex_mread & ex_rwrite &
                     ((id_use_rs1 & (id_rs1 == ex_wreg)) | (id_use_rs2 & (id_rs2 == ex_wreg)));

   // A taken branch discards the dependent ID instruction, so its load-use is not a stall.
   assign count_en = mem_stall | (lu_stall & ~ex_branch_taken);

   always_comb begin
      pc_en          = 1'b1;
      ifid_en        = 1'b1;
      idex_en        = 1'b1;
      exmem_en       = 1'b1;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      memwb_flush    = 1'b0;
      pc_take_branch = 1'b0;
      if (rst) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (mem_stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         pc_take_branch = 1'b1;
         ifid_flush     = 1'b1;
         idex_flush     = 1'b1;
      end else if (lu_stall) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         wcnt_q         <= 4'd0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (count_en && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; three instances cover MEM_WAIT = 2, 0 and 3.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_rs1, id_rs2, ex_wreg;
   logic       id_use_rs1, id_use_rs2, ex_rwrite, ex_mread, ex_branch_taken;
   logic       mem_mread, mem_mwrite;

   logic        pc_en2, ifid_en2, idex_en2, exmem_en2, ifid_fl2, idex_fl2, memwb_fl2, br2;
   logic        pc_en0, ifid_en0, idex_en0, exmem_en0, ifid_fl0, idex_fl0, memwb_fl0, br0;
   logic        pc_en3, ifid_en3, idex_en3, exmem_en3, ifid_fl3, idex_fl3, memwb_fl3, br3;
   logic [15:0] cnt2, cnt0, cnt3;
   logic [7:0]  ctl2, ctl0, ctl3;

   int checks = 0;
   int errors = 0;

   // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, pc_take_branch}
   localparam logic [7:0] Norm = 8'b1111_0000;
   localparam logic [7:0] Mems = 8'b0000_0010;
   localparam logic [7:0] Br   = 8'b1111_1101;
   localparam logic [7:0] Lu   = 8'b0011_0100;
   localparam logic [7:0] Rst  = 8'b0000_0000;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_WAIT(2)) dut2 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_wreg(ex_wreg), .ex_rwrite(ex_rwrite), .ex_mread(ex_mread),
      .ex_branch_taken(ex_branch_taken), .mem_mread(mem_mread), .mem_mwrite(mem_mwrite),
      .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2), .exmem_en(exmem_en2),
      .ifid_flush(ifid_fl2), .idex_flush(idex_fl2), .memwb_flush(memwb_fl2),
      .pc_take_branch(br2), .stall_cycles(cnt2)
   );

   hazard_ctrl #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_wreg(ex_wreg), .ex_rwrite(ex_rwrite), .ex_mread(ex_mread),
      .ex_branch_taken(ex_branch_taken), .mem_mread(mem_mread), .mem_mwrite(mem_mwrite),
      .pc_en(pc_en0), .ifid_en(ifid_en0), .idex_en(idex_en0), .exmem_en(exmem_en0),
      .ifid_flush(ifid_fl0), .idex_flush(idex_fl0), .memwb_flush(memwb_fl0),
      .pc_take_branch(br0), .stall_cycles(cnt0)
   );

   hazard_ctrl #(.MEM_WAIT(3)) dut3 (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_wreg(ex_wreg), .ex_rwrite(ex_rwrite), .ex_mread(ex_mread),
      .ex_branch_taken(ex_branch_taken), .mem_mread(mem_mread), .mem_mwrite(mem_mwrite),
      .pc_en(pc_en3), .ifid_en(ifid_en3), .idex_en(idex_en3), .exmem_en(exmem_en3),
      .ifid_flush(ifid_fl3), .idex_flush(idex_fl3), .memwb_flush(memwb_fl3),
      .pc_take_branch(br3), .stall_cycles(cnt3)
   );

   assign ctl2 = {pc_en2, ifid_en2, idex_en2, exmem_en2, ifid_fl2, idex_fl2, memwb_fl2, br2};
   assign ctl0 = {pc_en0, ifid_en0, idex_en0, exmem_en0, ifid_fl0, idex_fl0, memwb_fl0, br0};
   assign ctl3 = {pc_en3, ifid_en3, idex_en3, exmem_en3, ifid_fl3, idex_fl3, memwb_fl3, br3};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      id_rs1 = 3'd0; id_rs2 = 3'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_wreg = 3'd0; ex_rwrite = 1'b0; ex_mread = 1'b0; ex_branch_taken = 1'b0;
      mem_mread = 1'b0; mem_mwrite = 1'b0;
      step();
      step();

      // Reset aborts an access in progress
      rst = 1'b0; mem_mread = 1'b1; settle();
      chk("access_start", {8'd0, ctl2}, {8'd0, Mems});
      step();
      rst = 1'b1; settle();
      chk("rst_ctl_a", {8'd0, ctl2}, {8'd0, Rst});
      chk("rst_ctl_b", {8'd0, ctl3}, {8'd0, Rst});
      step();
      chk("rst_ctl_c", {8'd0, ctl2}, {8'd0, Rst});
      step();
      rst = 1'b0; mem_mread = 1'b0; settle();
      chk("post_rst_ctl", {8'd0, ctl2}, {8'd0, Norm});
      chk("post_rst_cnt2", cnt2, 16'd0);
      chk("post_rst_cnt3", cnt3, 16'd0);

      // Load-use decode, combinational only
      ex_mread = 1'b1; ex_rwrite = 1'b1; ex_wreg = 3'd3;
      id_rs1 = 3'd5; id_use_rs1 = 1'b1; id_rs2 = 3'd3; id_use_rs2 = 1'b0; settle();
      chk("lu_unused_rs2", {8'd0, ctl2}, {8'd0, Norm});
      id_rs1 = 3'd3; settle();
      chk("lu_rs1", {8'd0, ctl2}, {8'd0, Lu});
      ex_rwrite = 1'b0; settle();
      chk("lu_no_rwrite", {8'd0, ctl2}, {8'd0, Norm});
      ex_rwrite = 1'b1; ex_wreg = 3'd0; id_rs1 = 3'd0; settle();
      chk("lu_reg0", {8'd0, ctl2}, {8'd0, Lu});

      // Load-use: one bubble
      ex_wreg = 3'd3; id_rs1 = 3'd5; id_rs2 = 3'd3; id_use_rs2 = 1'b1; settle();
      chk("lu_rs2", {8'd0, ctl2}, {8'd0, Lu});
      step();
      ex_mread = 1'b0; ex_rwrite = 1'b0; settle();
      chk("lu_release", {8'd0, ctl2}, {8'd0, Norm});
      chk("lu_cnt", cnt2, 16'd1);

      // Memory wait, MEM_WAIT=2 and MEM_WAIT=0
      mem_mread = 1'b1; settle();
      chk("mw_c1", {8'd0, ctl2}, {8'd0, Mems});
      chk("mw0_c1", {8'd0, ctl0}, {8'd0, Norm});
      step();
      chk("mw_c2", {8'd0, ctl2}, {8'd0, Mems});
      step();
      chk("mw_c3", {8'd0, ctl2}, {8'd0, Norm});
      mem_mread = 1'b0;
      step();
      chk("mw_cnt2", cnt2, 16'd3);
      chk("mw_cnt0", cnt0, 16'd1);
      step();
      chk("idle_ctl", {8'd0, ctl3}, {8'd0, Norm});
      chk("idle_cnt3", cnt3, 16'd4);

      // Branch held off by a store wait, MEM_WAIT=3
      mem_mwrite = 1'b1; ex_branch_taken = 1'b1; settle();
      chk("brs_c1", {8'd0, ctl3}, {8'd0, Mems});
      chk("brs0_c1", {8'd0, ctl0}, {8'd0, Br});
      step();
      chk("brs_c2", {8'd0, ctl3}, {8'd0, Mems});
      step();
      chk("brs_c3", {8'd0, ctl3}, {8'd0, Mems});
      step();
      mem_mwrite = 1'b0; settle();
      chk("brs_c4", {8'd0, ctl3}, {8'd0, Br});
      step();
      ex_branch_taken = 1'b0; settle();
      chk("brs_c5", {8'd0, ctl3}, {8'd0, Norm});
      chk("brs_cnt3", cnt3, 16'd7);

      // Branch overrides load-use
      ex_mread = 1'b1; ex_rwrite = 1'b1; ex_branch_taken = 1'b1; settle();
      chk("brlu_ctl", {8'd0, ctl0}, {8'd0, Br});
      step();
      chk("brlu_cnt0", cnt0, 16'd1);
      chk("brlu_cnt2", cnt2, 16'd5);

      // Saturation under continuous load-use
      ex_branch_taken = 1'b0; settle();
      chk("sat_lu", {8'd0, ctl0}, {8'd0, Lu});
      for (int i = 0; i < 65533; i++) step();
      chk("sat_fffe", cnt0, 16'hFFFE);
      step();
      chk("sat_ffff", cnt0, 16'hFFFF);
      for (int i = 0; i < 4466; i++) step();
      chk("sat_hold0", cnt0, 16'hFFFF);
      chk("sat_hold2", cnt2, 16'hFFFF);

      rst = 1'b1;
      step();
      chk("final_rst_cnt", cnt0, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
